game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
- Game-flow controller for the 2x2 tile game board datapath.
- Takes debounced direction and restart flags and arbitrates them into single move requests to the board-merge engine over a req/ack handshake.
- After each effective move it spawns a new tile from an LFSR, then evaluates win and lose conditions.
- Owns the authoritative 12-bit board register, the game status and the move counter.

Parameters:
- WIN_EXP, 7, tile exponent that ends the game as a win (3-bit; 7 = tile 128).
- ACK_TIMEOUT, 16, max cycles to wait for mv_ack before aborting the move.
- LFSR_SEED, 8'hB5, LFSR value loaded at reset (must be non-zero).

Ports:
- clk  in  1  system clock.
- rst_sw  in  1  asynchronous, active-high reset.
- start  in  1  level; game may run only while high.
- restart_flag  in  1  1-cycle pulse; restarts the game.
- act_flag  in  4  1-cycle direction pulses; index 0..3 = up, down, left, right.
- mv_req  out  1  move request to merge engine.
- mv_dir  out  2  direction, valid while mv_req=1.
- mv_board_out  out  12  board presented to the engine (equals board).
- mv_ack  in  1  engine done; result fields valid in the same cycle.
- mv_board_in  in  12  board after the move.
- mv_changed  in  1  move altered the board.
- board  out  12  current board; cell i = bits [3i+2:3i], 0 = empty, value = exponent.
- game_status  out  2  00 idle, 01 play, 10 win, 11 lose.
- move_cnt  out  8  effective moves this game, saturating at 255.
- timeout_err  out  1  sticky; set on ACK timeout.

Behaviour:
- Reset (async): state IDLE, board 0, game_status 00, move_cnt 0, mv_req 0, mv_dir 0, timeout_err 0, LFSR = LFSR_SEED.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1; advances every cycle, including in IDLE.
- IDLE: when start=1, go to INIT.
- INIT: clear board, move_cnt and timeout_err, then run two SPAWN passes, then go to WAIT.
- WAIT (status 01):
  - Act on act_flag only when it is non-zero.
  - Lowest set index wins; the other bits that cycle are discarded.
  - Latch mv_dir, assert mv_req next cycle, go to REQ.
  - act_flag is ignored in every other state.
- REQ:
  - Hold mv_req and mv_dir stable until mv_ack. mv_req drops the cycle after the ack.
  - On ack with mv_changed=1: board <= mv_board_in, move_cnt +1 (saturating), go to SPAWN, then CHECK.
  - On ack with mv_changed=0: no board update, no count, no spawn; go to CHECK.
  - No ack within ACK_TIMEOUT cycles of mv_req rising: drop mv_req, set timeout_err, board unchanged, go to WAIT.
- SPAWN (1 cycle):
  - Scan from cell lfsr[1:0] upward mod 4; the first empty cell gets exponent 2 if lfsr[7:5]==0, else 1.
  - No empty cell: no change.
- CHECK (1 cycle):
  - Any cell == WIN_EXP: WIN (status 10).
  - Else if no empty cell and no equal adjacent pair among (0,1), (2,3), (0,2), (1,3): LOSE (status 11).
  - Else WAIT.
- WIN / LOSE: hold board and move_cnt; accept only restart_flag.
- restart_flag:
  - Honoured in every state, including mid-REQ; mv_req drops the next cycle.
  - If start=1, go to INIT; otherwise clear board and go to IDLE.
  - A late mv_ack after a restart is ignored.
- start falling to 0: go to IDLE at the next WAIT, WIN or LOSE state; board is held; status 00.

Optional Feature:
- UNDO_EN: adds input undo_flag (1-cycle pulse) plus a 12-bit prev_board register and a valid bit.
  - The current board is copied to prev_board on each effective move, before the move is applied.
  - undo_flag in WAIT with valid=1: board <= prev_board, move_cnt -1, valid cleared (one level of undo only).
  - undo_flag in LOSE with valid=1: same restore, and status returns to 01.
  - undo_flag is ignored elsewhere; valid is cleared by reset and INIT.
  - Without the macro: no port, no registers.

Test Plan:
- Reset then start=1: within 4 cycles status 01; board has exactly two non-zero cells, each of value 1 or 2; move_cnt 0.
- In WAIT, act_flag=4'b0110: mv_req=1 with mv_dir=1; hold mv_ack low for 3 cycles and check mv_dir stays stable; ack with mv_changed=0: board unchanged, move_cnt 0, back to WAIT.
- Ack with mv_board_in=12'o0011, mv_changed=1: board has cells 0 and 1 equal to 1 plus one new tile in an empty cell; move_cnt 1.
- With WIN_EXP=7, ack with mv_board_in=12'o0070, changed=1: status 10; further act_flag pulses produce no mv_req.
- Ack with mv_board_in=12'o1221, changed=1 (full board, no equal adjacent pair): no spawn, status 11; restart_flag returns status to 01 with move_cnt 0.
- No mv_ack for ACK_TIMEOUT=16 cycles: mv_req drops, timeout_err=1, status 01, board unchanged.

Source files
------------

// File: rtl/game_sequencer.sv
// Game-flow controller for the 2x2 tile board: arbitrates direction pulses into
// merge-engine requests, spawns tiles from an LFSR and decides win/lose.
// Optional build macro UNDO_EN adds a one-level undo (undo_flag input).
module game_sequencer #(
  parameter logic [2:0] WIN_EXP     = 3'd7,
  parameter int         ACK_TIMEOUT = 16,
  parameter logic [7:0] LFSR_SEED   = 8'hB5
) (
  input  logic        clk,
  input  logic        rst_sw,
  input  logic        start,
  input  logic        restart_flag,
  input  logic [3:0]  act_flag,
`ifdef UNDO_EN
  input  logic        undo_flag,
`endif
  output logic        mv_req,
  output logic [1:0]  mv_dir,
  output logic [11:0] mv_board_out,
  input  logic        mv_ack,
  input  logic [11:0] mv_board_in,
  input  logic        mv_changed,
  output logic [11:0] board,
  output logic [1:0]  game_status,
  output logic [7:0]  move_cnt,
  output logic        timeout_err
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SPAWN, S_CHECK, S_WAIT, S_REQ, S_WIN, S_LOSE
  } state_t;

  state_t          state_r;
  logic [11:0]     board_r;
  logic [1:0]      status_r;
  logic [7:0]      move_cnt_r;
  logic            mv_req_r;
  logic [1:0]      mv_dir_r;
  logic            timeout_err_r;
  logic [7:0]      lfsr_r;
  logic [TW-1:0]   tmo_cnt_r;
  logic [1:0]      spawn_left_r;
`ifdef UNDO_EN
  logic [11:0]     prev_board_r;
  logic            prev_valid_r;
`endif

  // First empty cell scanning upward from lfsr[1:0] gets a 1 (or a 2 when lfsr[7:5]==0)
  function automatic logic [11:0] spawn_tile(input logic [11:0] b, input logic [7:0] l);
    logic [11:0] r;
    logic        done;
    logic [1:0]  idx;
    r    = b;
    done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = l[1:0] + 2'(k);
      if (!done && (b[int'(idx)*3 +: 3] == 3'd0)) begin
        r[int'(idx)*3 +: 3] = (l[7:5] == 3'd0) ? 3'd2 : 3'd1;
        done = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic has_win(input logic [11:0] b);
    logic w;
    w = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (b[i*3 +: 3] == WIN_EXP) w = 1'b1;
    end
    return w;
  endfunction

  function automatic logic is_stuck(input logic [11:0] b);
    logic full;
    logic pair;
    full = (b[2:0] != 3'd0) && (b[5:3] != 3'd0) && (b[8:6] != 3'd0) && (b[11:9] != 3'd0);
    pair = (b[2:0] == b[5:3]) || (b[8:6] == b[11:9]) ||
           (b[2:0] == b[8:6]) || (b[5:3] == b[11:9]);
    return full && !pair;
  endfunction

  function automatic logic [1:0] pick_dir(input logic [3:0] f);
    if (f[0])      return 2'd0;
    else if (f[1]) return 2'd1;
    else if (f[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Free-running tile-placement LFSR, x^8+x^6+x^5+x^4+1
  always_ff @(posedge clk or posedge rst_sw) begin
    if (rst_sw) lfsr_r <= LFSR_SEED;
    else        lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
  end

  // Game-flow state machine with all outputs registered
  always_ff @(posedge clk or posedge rst_sw) begin
    if (rst_sw) begin
      state_r       <= S_IDLE;
      board_r       <= 12'd0;
      status_r      <= 2'b00;
      move_cnt_r    <= 8'd0;
      mv_req_r      <= 1'b0;
      mv_dir_r      <= 2'd0;
      timeout_err_r <= 1'b0;
      tmo_cnt_r     <= '0;
      spawn_left_r  <= 2'd0;
`ifdef UNDO_EN
      prev_board_r  <= 12'd0;
      prev_valid_r  <= 1'b0;
`endif
    end else if (restart_flag) begin
      // Abandons any request in flight; a later ack lands outside S_REQ and is dropped
      mv_req_r  <= 1'b0;
      tmo_cnt_r <= '0;
      if (start) begin
        state_r <= S_INIT;
      end else begin
        board_r  <= 12'd0;
        status_r <= 2'b00;
        state_r  <= S_IDLE;
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) state_r <= S_INIT;
        end
        S_INIT: begin
          board_r       <= 12'd0;
          move_cnt_r    <= 8'd0;
          timeout_err_r <= 1'b0;
          status_r      <= 2'b01;
          spawn_left_r  <= 2'd2;
          state_r       <= S_SPAWN;
`ifdef UNDO_EN
          prev_valid_r  <= 1'b0;
`endif
        end
        S_SPAWN: begin
          board_r <= spawn_tile(board_r, lfsr_r);
          case (spawn_left_r)
            2'd2:    spawn_left_r <= 2'd1;
            2'd1: begin
              spawn_left_r <= 2'd0;
              state_r      <= S_WAIT;
            end
            default: state_r <= S_CHECK;
          endcase
        end
        S_CHECK: begin
          if (has_win(board_r)) begin
            status_r <= 2'b10;
            state_r  <= S_WIN;
          end else if (is_stuck(board_r)) begin
            status_r <= 2'b11;
            state_r  <= S_LOSE;
          end else begin
            state_r  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!start) begin
            status_r <= 2'b00;
            state_r  <= S_IDLE;
          end
`ifdef UNDO_EN
          else if (undo_flag && prev_valid_r) begin
            board_r      <= prev_board_r;
            move_cnt_r   <= (move_cnt_r != 8'd0) ? move_cnt_r - 8'd1 : 8'd0;
            prev_valid_r <= 1'b0;
          end
`endif
          else if (act_flag != 4'd0) begin
            mv_dir_r  <= pick_dir(act_flag);
            mv_req_r  <= 1'b1;
            tmo_cnt_r <= '0;
            state_r   <= S_REQ;
          end
        end
        S_REQ: begin
          if (mv_ack) begin
            mv_req_r <= 1'b0;
            if (mv_changed) begin
              board_r      <= mv_board_in;
              move_cnt_r   <= (move_cnt_r == 8'd255) ? 8'd255 : move_cnt_r + 8'd1;
              spawn_left_r <= 2'd0;
              state_r      <= S_SPAWN;
`ifdef UNDO_EN
              prev_board_r <= board_r;
              prev_valid_r <= 1'b1;
`endif
            end else begin
              state_r <= S_CHECK;
            end
          end else if (tmo_cnt_r == TMO_LAST) begin
            mv_req_r      <= 1'b0;
            timeout_err_r <= 1'b1;
            state_r       <= S_WAIT;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end
        end
        S_WIN: begin
          if (!start) begin
            status_r <= 2'b00;
            state_r  <= S_IDLE;
          end
        end
        S_LOSE: begin
          if (!start) begin
            status_r <= 2'b00;
            state_r  <= S_IDLE;
          end
`ifdef UNDO_EN
          else if (undo_flag && prev_valid_r) begin
            board_r      <= prev_board_r;
            move_cnt_r   <= (move_cnt_r != 8'd0) ? move_cnt_r - 8'd1 : 8'd0;
            prev_valid_r <= 1'b0;
            status_r     <= 2'b01;
            state_r      <= S_WAIT;
          end
`endif
        end
        default: begin
          mv_req_r <= 1'b0;
          status_r <= 2'b00;
          state_r  <= S_IDLE;
        end
      endcase
    end
  end

  assign mv_req       = mv_req_r;
  assign mv_dir       = mv_dir_r;
  assign mv_board_out = board_r;
  assign board        = board_r;
  assign game_status  = status_r;
  assign move_cnt     = move_cnt_r;
  assign timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized self-checking bench for game_sequencer against a cell-level game model.
module tb_game_sequencer;

  localparam logic [7:0] SEED = 8'hB5;
  localparam int         TMO  = 16;

  logic        clk, rst_sw, start, restart_flag;
  logic [3:0]  act_flag;
  logic        mv_req, mv_ack, mv_changed;
  logic [1:0]  mv_dir, game_status;
  logic [11:0] mv_board_out, mv_board_in, board;
  logic [7:0]  move_cnt;
  logic        timeout_err;
`ifdef UNDO_EN
  logic        undo_flag;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  m_lfsr;
  logic [11:0] exp_board;
  logic [1:0]  exp_status;
  int          exp_cnt;

  game_sequencer #(.WIN_EXP(3'd7), .ACK_TIMEOUT(TMO), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_sw(rst_sw), .start(start), .restart_flag(restart_flag),
    .act_flag(act_flag),
`ifdef UNDO_EN
    .undo_flag(undo_flag),
`endif
    .mv_req(mv_req), .mv_dir(mv_dir), .mv_board_out(mv_board_out),
    .mv_ack(mv_ack), .mv_board_in(mv_board_in), .mv_changed(mv_changed),
    .board(board), .game_status(game_status), .move_cnt(move_cnt),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  // Reference LFSR: the value seen by the DUT during each cycle
  always @(posedge clk or posedge rst_sw) begin
    if (rst_sw) m_lfsr <= SEED;
    else        m_lfsr <= lfsr_next(m_lfsr);
  end

  function automatic logic [11:0] m_spawn(input logic [11:0] b, input logic [7:0] key);
    int cells[4];
    int pos;
    logic [11:0] r;
    for (int i = 0; i < 4; i++) cells[i] = int'(b[i*3 +: 3]);
    for (int k = 0; k < 4; k++) begin
      pos = (int'(key % 8'd4) + k) % 4;
      if (cells[pos] == 0) begin
        cells[pos] = ((key / 8'd32) == 8'd0) ? 2 : 1;
        break;
      end
    end
    r = 12'd0;
    for (int i = 0; i < 4; i++) r[i*3 +: 3] = 3'(cells[i]);
    return r;
  endfunction

  function automatic logic [1:0] m_status(input logic [11:0] b);
    int c[4];
    int empty;
    bit pair;
    empty = 0;
    for (int i = 0; i < 4; i++) begin
      c[i] = int'(b[i*3 +: 3]);
      if (c[i] == 7) return 2'b10;
      if (c[i] == 0) empty++;
    end
    pair = (c[0] == c[1]) || (c[2] == c[3]) || (c[0] == c[2]) || (c[1] == c[3]);
    if (empty == 0 && !pair) return 2'b11;
    return 2'b01;
  endfunction

  function automatic int count_tiles(input logic [11:0] b);
    int n = 0;
    for (int i = 0; i < 4; i++) if (b[i*3 +: 3] inside {3'd1, 3'd2}) n++;
    return n;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Game entry via start rising (use_restart=0) or a restart pulse (use_restart=1)
  task automatic do_init(input bit use_restart);
    logic [7:0] k1, k2;
    if (use_restart) restart_flag = 1'b1;
    else             start = 1'b1;
    tick();
    restart_flag = 1'b0;
    check_eq("init_req_low", 32'(mv_req), 32'd0);
    tick();
    k1 = m_lfsr;
    tick();
    k2 = m_lfsr;
    tick();
    exp_board  = m_spawn(m_spawn(12'd0, k1), k2);
    exp_status = 2'b01;
    exp_cnt    = 0;
    check_eq("init_status", 32'(game_status), 32'h1);
    check_eq("init_board", 32'(board), 32'(exp_board));
    check_eq("init_tiles", 32'(count_tiles(board)), 32'd2);
    check_eq("init_cnt", 32'(move_cnt), 32'd0);
    check_eq("init_tmo", 32'(timeout_err), 32'd0);
  endtask

  task automatic do_move(input logic [3:0] flags, input int delay,
                         input logic changed, input logic [11:0] bin);
    logic [1:0] edir;
    logic [7:0] key;
    edir = flags[0] ? 2'd0 : flags[1] ? 2'd1 : flags[2] ? 2'd2 : 2'd3;
    act_flag = flags;
    tick();
    act_flag = 4'd0;
    check_eq("req_rise", 32'(mv_req), 32'd1);
    check_eq("req_dir", 32'(mv_dir), 32'(edir));
    check_eq("req_board_out", 32'(mv_board_out), 32'(exp_board));
    for (int d = 0; d < delay; d++) begin
      tick();
      check_eq("req_hold", 32'(mv_req), 32'd1);
      check_eq("dir_hold", 32'(mv_dir), 32'(edir));
    end
    mv_ack = 1'b1; mv_changed = changed; mv_board_in = bin;
    tick();
    mv_ack = 1'b0; mv_changed = 1'b0;
    key = m_lfsr;
    check_eq("req_drop", 32'(mv_req), 32'd0);
    tick();
    tick();
    if (changed) begin
      exp_board = m_spawn(bin, key);
      exp_cnt   = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
    end
    exp_status = m_status(exp_board);
    check_eq("move_board", 32'(board), 32'(exp_board));
    check_eq("move_status", 32'(game_status), 32'(exp_status));
    check_eq("move_cnt", 32'(move_cnt), 32'(exp_cnt));
  endtask

  initial begin
    logic [11:0] saved;
    logic [11:0] rb;
    rst_sw = 1'b1; start = 1'b0; restart_flag = 1'b0; act_flag = 4'd0;
    mv_ack = 1'b0; mv_changed = 1'b0; mv_board_in = 12'd0;
`ifdef UNDO_EN
    undo_flag = 1'b0;
`endif
    exp_board = 12'd0; exp_status = 2'b00; exp_cnt = 0;
    repeat (3) tick();
    rst_sw = 1'b0;
    tick();
    check_eq("rst_board", 32'(board), 32'd0);
    check_eq("rst_status", 32'(game_status), 32'd0);
    check_eq("rst_cnt", 32'(move_cnt), 32'd0);
    check_eq("rst_req", 32'(mv_req), 32'd0);
    check_eq("rst_dir", 32'(mv_dir), 32'd0);
    check_eq("rst_tmo", 32'(timeout_err), 32'd0);
    repeat (2) tick();

    do_init(1'b0);
    do_move(4'b0110, 3, 1'b0, 12'o7777);
    do_move(4'b0001, 0, 1'b1, 12'o0011);
    do_move(4'b1000, 1, 1'b1, 12'o0070);
    check_eq("win_status", 32'(game_status), 32'h2);
    for (int i = 0; i < 3; i++) begin
      act_flag = 4'b0001 << i;
      tick();
      act_flag = 4'd0;
      tick();
      check_eq("win_no_req", 32'(mv_req), 32'd0);
    end
    check_eq("win_board_hold", 32'(board), 32'(exp_board));
    do_init(1'b1);

    do_move(4'b0100, 2, 1'b1, 12'o1221);
    check_eq("lose_status", 32'(game_status), 32'h3);
    do_init(1'b1);

    // Ack never arrives
    saved = exp_board;
    act_flag = 4'b1000;
    tick();
    act_flag = 4'd0;
    check_eq("tmo_req_rise", 32'(mv_req), 32'd1);
    repeat (TMO - 1) tick();
    check_eq("tmo_req_still", 32'(mv_req), 32'd1);
    tick();
    check_eq("tmo_req_drop", 32'(mv_req), 32'd0);
    check_eq("tmo_err", 32'(timeout_err), 32'd1);
    tick();
    check_eq("tmo_status", 32'(game_status), 32'h1);
    check_eq("tmo_board", 32'(board), 32'(saved));
    do_move(4'b0010, 0, 1'b0, 12'o0000);
    check_eq("tmo_sticky", 32'(timeout_err), 32'd1);

    // Restart mid-request, then a stale ack must be ignored
    act_flag = 4'b0100;
    tick();
    act_flag = 4'd0;
    tick();
    do_init(1'b1);
    mv_ack = 1'b1; mv_changed = 1'b1; mv_board_in = 12'o7777;
    tick();
    mv_ack = 1'b0; mv_changed = 1'b0;
    repeat (2) tick();
    check_eq("late_ack_board", 32'(board), 32'(exp_board));
    check_eq("late_ack_status", 32'(game_status), 32'h1);
    check_eq("late_ack_req", 32'(mv_req), 32'd0);

    // start dropping parks the game in idle with the board held
    start = 1'b0;
    tick();
    tick();
    check_eq("stop_status", 32'(game_status), 32'h0);
    check_eq("stop_board", 32'(board), 32'(exp_board));
    act_flag = 4'b0001;
    tick();
    act_flag = 4'd0;
    tick();
    check_eq("stop_no_req", 32'(mv_req), 32'd0);
    do_init(1'b0);

    // Move counter saturation
    for (int i = 0; i < 258; i++) do_move(4'b0001, 0, 1'b1, 12'o0000);
    check_eq("cnt_sat", 32'(move_cnt), 32'd255);
    do_init(1'b1);

    // Randomized play
    for (int i = 0; i < 120; i++) begin
      for (int c = 0; c < 4; c++) rb[c*3 +: 3] = 3'($urandom_range(0, 7));
      do_move(4'($urandom_range(1, 15)), $urandom_range(0, 5), 1'($urandom_range(0, 1)), rb);
      if (exp_status != 2'b01) do_init(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
